// File: rtl/write_back_unit.sv
// write_back_unit: final pipeline stage. Retires instructions from the
// memory-access stage, waits on data-memory load responses, aligns and extends
// load data, flags misaligned or illegal loads, and issues the register-file
// write.
//
// Ports:
//   clock_i, nreset_i              clock, asynchronous active-low reset
//   mem_*_i                        instruction and operands from memory-access stage
//   mem_stall_o                    combinational hold of the memory-access stage
//   dmem_rdata_i, dmem_rvalid_i    load response (word-aligned data)
//   rf_wen_o, rf_waddr_o, rf_wdata_o   register-file write port (registered)
//   retire_valid_o, retire_pc_o    retirement strobe and PC (registered)
//   load_fault_o                   one-cycle pulse for a faulted load
//   instret_o                      retired-instruction counter
//
// Configuration: define WB_INSTRET_EN to build the 64-bit retire counter;
// without it instret_o is tied to zero.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ILEN
`define ILEN 32
`endif
`ifndef PC_INIT
`define PC_INIT 32'h0000_0000
`endif

module write_back_unit #(
  parameter logic [`XLEN-1:0] PC_INIT = `PC_INIT
) (
  input  logic              clock_i,
  input  logic              nreset_i,
  input  logic              mem_bubble_i,
  input  logic [`XLEN-1:0]  mem_pc_i,
  input  logic [`ILEN-1:0]  mem_instruct_i,
  input  logic [5:0]        mem_instruct_type_i,
  input  logic [4:0]        mem_rdt_addr_i,
  input  logic [`XLEN-1:0]  mem_rdt_wdata_i,
  input  logic              mem_is_mem_op_i,
  input  logic              mem_mem_op_type_i,
  input  logic [`XLEN-1:0]  mem_mem_addr_i,
  output logic              mem_stall_o,
  input  logic [`XLEN-1:0]  dmem_rdata_i,
  input  logic              dmem_rvalid_i,
  output logic              rf_wen_o,
  output logic [4:0]        rf_waddr_o,
  output logic [`XLEN-1:0]  rf_wdata_o,
  output logic              retire_valid_o,
  output logic [`XLEN-1:0]  retire_pc_o,
  output logic              load_fault_o,
  output logic [63:0]       instret_o
);

  localparam int unsigned XLEN = `XLEN;
  localparam int unsigned ILEN = `ILEN;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_next;
  logic             complete;
  logic             stall;
  logic             is_load;
  logic             is_store;
  logic [2:0]       funct3;
  logic [1:0]       lane;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [XLEN-1:0]  load_data;
  logic             load_fault;
  logic             unused_bits;

  // Instruction classification
  assign is_load  = !mem_bubble_i && mem_is_mem_op_i && !mem_mem_op_type_i;
  assign is_store = !mem_bubble_i && mem_is_mem_op_i &&  mem_mem_op_type_i;
  assign funct3   = mem_instruct_i[14:12];
  assign lane     = mem_mem_addr_i[1:0];

  // Fields that write-back does not consume
  assign unused_bits = ^{mem_instruct_i[ILEN-1:15], mem_instruct_i[11:0],
                         mem_instruct_type_i, mem_mem_addr_i[XLEN-1:2]};

  // State register
  always_ff @(posedge clock_i or negedge nreset_i) begin : state_reg
    if (!nreset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic
  always_comb begin : next_state_comb
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (is_load && !dmem_rvalid_i) begin
          state_next = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion and stall decode; the stalled stage holds its inputs, so the
  // load fields are still valid when the response arrives in WAIT_LOAD.
  always_comb begin : output_comb
    complete = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        complete = !mem_bubble_i && (!is_load || dmem_rvalid_i);
        stall    = is_load && !dmem_rvalid_i;
      end
      WAIT_LOAD: begin
        complete = dmem_rvalid_i;
        stall    = !dmem_rvalid_i;
      end
      default: begin
        complete = 1'b0;
        stall    = 1'b0;
      end
    endcase
  end

  // Stall is forced low while reset is asserted
  assign mem_stall_o = stall && nreset_i;

  // Lane selection from the word-aligned response
  always_comb begin : lane_select
    lane_byte = dmem_rdata_i[7:0];
    case (lane)
      2'd0: lane_byte = dmem_rdata_i[7:0];
      2'd1: lane_byte = dmem_rdata_i[15:8];
      2'd2: lane_byte = dmem_rdata_i[23:16];
      2'd3: lane_byte = dmem_rdata_i[31:24];
      default: lane_byte = dmem_rdata_i[7:0];
    endcase
    lane_half = lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  end

  // Load extension and fault detection
  always_comb begin : load_format
    load_data  = '0;
    load_fault = 1'b0;
    case (funct3)
      3'b000: load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b100: load_data = {{(XLEN-8){1'b0}}, lane_byte};
      3'b001: begin
        load_fault = lane[0];
        load_data  = {{(XLEN-16){lane_half[15]}}, lane_half};
      end
      3'b101: begin
        load_fault = lane[0];
        load_data  = {{(XLEN-16){1'b0}}, lane_half};
      end
      3'b010: begin
        load_fault = (lane != 2'd0);
        load_data  = dmem_rdata_i;
      end
      default: load_fault = 1'b1;
    endcase
  end

  // Registered write-back and retirement outputs
  always_ff @(posedge clock_i or negedge nreset_i) begin : wb_regs
    if (!nreset_i) begin
      rf_wen_o       <= 1'b0;
      rf_waddr_o     <= 5'd0;
      rf_wdata_o     <= '0;
      retire_valid_o <= 1'b0;
      retire_pc_o    <= PC_INIT;
      load_fault_o   <= 1'b0;
    end else begin
      retire_valid_o <= complete;
      load_fault_o   <= complete && is_load && load_fault;
      rf_wen_o       <= complete && (mem_rdt_addr_i != 5'd0) && !is_store
                        && !(is_load && load_fault);
      if (complete) begin
        retire_pc_o <= mem_pc_i;
        rf_waddr_o  <= mem_rdt_addr_i;
        rf_wdata_o  <= is_load ? load_data : mem_rdt_wdata_i;
      end
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Retire counter, faulted loads included; wraps naturally
  always_ff @(posedge clock_i or negedge nreset_i) begin : instret_reg
    if (!nreset_i) begin
      instret_q <= 64'd0;
    end else if (complete) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// tb_write_back_unit: directed vectors for write_back_unit with hand-computed
// expected values for ALU retire, delayed and immediate loads, extension,
// faults, stores, reset during a pending load and the retire counter.

module tb_write_back_unit;

  localparam logic [31:0] PC_RST = 32'h0000_1000;

  logic        clock_i;
  logic        nreset_i;
  logic        mem_bubble_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_instruct_i;
  logic [5:0]  mem_instruct_type_i;
  logic [4:0]  mem_rdt_addr_i;
  logic [31:0] mem_rdt_wdata_i;
  logic        mem_is_mem_op_i;
  logic        mem_mem_op_type_i;
  logic [31:0] mem_mem_addr_i;
  logic        mem_stall_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_rvalid_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        retire_valid_o;
  logic [31:0] retire_pc_o;
  logic        load_fault_o;
  logic [63:0] instret_o;

  int n_tests = 0;
  int n_fail  = 0;

  write_back_unit #(.PC_INIT(PC_RST)) dut (
    .clock_i             (clock_i),
    .nreset_i            (nreset_i),
    .mem_bubble_i        (mem_bubble_i),
    .mem_pc_i            (mem_pc_i),
    .mem_instruct_i      (mem_instruct_i),
    .mem_instruct_type_i (mem_instruct_type_i),
    .mem_rdt_addr_i      (mem_rdt_addr_i),
    .mem_rdt_wdata_i     (mem_rdt_wdata_i),
    .mem_is_mem_op_i     (mem_is_mem_op_i),
    .mem_mem_op_type_i   (mem_mem_op_type_i),
    .mem_mem_addr_i      (mem_mem_addr_i),
    .mem_stall_o         (mem_stall_o),
    .dmem_rdata_i        (dmem_rdata_i),
    .dmem_rvalid_i       (dmem_rvalid_i),
    .rf_wen_o            (rf_wen_o),
    .rf_waddr_o          (rf_waddr_o),
    .rf_wdata_o          (rf_wdata_o),
    .retire_valid_o      (retire_valid_o),
    .retire_pc_o         (retire_pc_o),
    .load_fault_o        (load_fault_o),
    .instret_o           (instret_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [31:0] instr,
                             input logic [4:0] rd, input logic [31:0] wdata,
                             input logic memop, input logic mtype,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic rvalid);
    mem_bubble_i      = 1'b0;
    mem_pc_i          = pc;
    mem_instruct_i    = instr;
    mem_rdt_addr_i    = rd;
    mem_rdt_wdata_i   = wdata;
    mem_is_mem_op_i   = memop;
    mem_mem_op_type_i = mtype;
    mem_mem_addr_i    = addr;
    dmem_rdata_i      = rdata;
    dmem_rvalid_i     = rvalid;
  endtask

  task automatic drive_bubble(input logic rvalid);
    mem_bubble_i      = 1'b1;
    mem_is_mem_op_i   = 1'b0;
    mem_mem_op_type_i = 1'b0;
    dmem_rvalid_i     = rvalid;
  endtask

  initial begin
    mem_instruct_type_i = 6'd0;
    mem_pc_i = '0; mem_instruct_i = '0; mem_rdt_addr_i = '0; mem_rdt_wdata_i = '0;
    mem_mem_addr_i = '0; dmem_rdata_i = '0;
    nreset_i = 1'b0;

    // Reset with a pending load presented: no stall, reset values
    drive_instr(32'h50, 32'h0000_0003, 5'd3, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    check("rst_stall", 64'(mem_stall_o), 64'd0);
    tick(); tick();
    check("rst_wen",     64'(rf_wen_o),       64'd0);
    check("rst_waddr",   64'(rf_waddr_o),     64'd0);
    check("rst_wdata",   64'(rf_wdata_o),     64'd0);
    check("rst_rvalid",  64'(retire_valid_o), 64'd0);
    check("rst_pc",      64'(retire_pc_o),    64'(PC_RST));
    check("rst_fault",   64'(load_fault_o),   64'd0);
    check("rst_instret", instret_o,           64'd0);
    drive_bubble(1'b0);
    nreset_i = 1'b1;
    tick();

    // ADD pc=0x100 rd=5
    drive_instr(32'h100, 32'h0000_0033, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1 check("add_stall", 64'(mem_stall_o), 64'd0);
    tick();
    check("add_wen",    64'(rf_wen_o),       64'd1);
    check("add_waddr",  64'(rf_waddr_o),     64'd5);
    check("add_wdata",  64'(rf_wdata_o),     64'hDEAD_BEEF);
    check("add_retire", 64'(retire_valid_o), 64'd1);
    check("add_pc",     64'(retire_pc_o),    64'h100);
    drive_bubble(1'b0);
    tick();
    check("bub_retire", 64'(retire_valid_o), 64'd0);
    check("bub_wen",    64'(rf_wen_o),       64'd0);
    check("bub_pc_hold", 64'(retire_pc_o),   64'h100);

    // LB addr=0x1003, response three cycles late
    drive_instr(32'h104, 32'h0000_0003, 5'd6, 32'h0, 1'b1, 1'b0, 32'h1003, 32'h80FF_FF7F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("lb_stall", 64'(mem_stall_o), 64'd1);
      tick();
      check("lb_wait_retire", 64'(retire_valid_o), 64'd0);
    end
    dmem_rvalid_i = 1'b1;
    #1 check("lb_stall_rel", 64'(mem_stall_o), 64'd0);
    tick();
    check("lb_wen",    64'(rf_wen_o),       64'd1);
    check("lb_waddr",  64'(rf_waddr_o),     64'd6);
    check("lb_wdata",  64'(rf_wdata_o),     64'hFFFF_FF80);
    check("lb_pc",     64'(retire_pc_o),    64'h104);

    // LHU addr=0x2002, response same cycle
    drive_instr(32'h108, 32'h0000_5003, 5'd7, 32'h0, 1'b1, 1'b0, 32'h2002, 32'hABCD_1234, 1'b1);
    #1 check("lhu_stall", 64'(mem_stall_o), 64'd0);
    tick();
    check("lhu_wen",   64'(rf_wen_o),   64'd1);
    check("lhu_wdata", 64'(rf_wdata_o), 64'h0000_ABCD);

    // LH sign extension, upper half
    drive_instr(32'h10C, 32'h0000_1003, 5'd8, 32'h0, 1'b1, 1'b0, 32'h3002, 32'h8001_0000, 1'b1);
    tick();
    check("lh_wdata", 64'(rf_wdata_o), 64'hFFFF_8001);

    // LBU lane 1 zero extension
    drive_instr(32'h110, 32'h0000_4003, 5'd9, 32'h0, 1'b1, 1'b0, 32'h3001, 32'h0000_9A00, 1'b1);
    tick();
    check("lbu_wdata", 64'(rf_wdata_o), 64'h0000_009A);

    // LW addr=0x2001: misaligned fault
    drive_instr(32'h114, 32'h0000_2003, 5'd10, 32'h0, 1'b1, 1'b0, 32'h2001, 32'h1111_2222, 1'b1);
    tick();
    check("lw_fault",  64'(load_fault_o),   64'd1);
    check("lw_wen",    64'(rf_wen_o),       64'd0);
    check("lw_retire", 64'(retire_valid_o), 64'd1);

    // Illegal funct3 011 faults as well
    drive_instr(32'h118, 32'h0000_3003, 5'd11, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1);
    tick();
    check("f3_fault", 64'(load_fault_o), 64'd1);
    check("f3_wen",   64'(rf_wen_o),     64'd0);

    // Store completes without rvalid and writes nothing
    drive_instr(32'h11C, 32'h0000_2023, 5'd12, 32'h55, 1'b1, 1'b1, 32'h2000, 32'h0, 1'b0);
    #1 check("st_stall", 64'(mem_stall_o), 64'd0);
    tick();
    check("st_retire", 64'(retire_valid_o), 64'd1);
    check("st_wen",    64'(rf_wen_o),       64'd0);
    check("st_fault",  64'(load_fault_o),   64'd0);
    check("st_pc",     64'(retire_pc_o),    64'h11C);

    // rd=0 retires without a write
    drive_instr(32'h120, 32'h0000_0033, 5'd0, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("x0_retire", 64'(retire_valid_o), 64'd1);
    check("x0_wen",    64'(rf_wen_o),       64'd0);

    // Stray rvalid with a bubble is ignored
    drive_bubble(1'b1);
    #1 check("stray_stall", 64'(mem_stall_o), 64'd0);
    tick();
    check("stray_retire", 64'(retire_valid_o), 64'd0);
    check("stray_wen",    64'(rf_wen_o),       64'd0);

    // Reset while waiting on a load
    drive_instr(32'h124, 32'h0000_2003, 5'd13, 32'h0, 1'b1, 1'b0, 32'h4000, 32'h0, 1'b0);
    tick();
    check("wl_stall", 64'(mem_stall_o), 64'd1);
    #2 nreset_i = 1'b0;
    #1;
    check("wl_rst_stall",  64'(mem_stall_o),    64'd0);
    check("wl_rst_wen",    64'(rf_wen_o),       64'd0);
    check("wl_rst_pc",     64'(retire_pc_o),    64'(PC_RST));
    check("wl_rst_retire", 64'(retire_valid_o), 64'd0);
    drive_bubble(1'b0);
    tick();
    nreset_i = 1'b1;
    drive_bubble(1'b1);
    tick();
    check("wl_abandon_wen",    64'(rf_wen_o),       64'd0);
    check("wl_abandon_retire", 64'(retire_valid_o), 64'd0);

    // Ten retires with interleaved bubbles
    for (int i = 0; i < 10; i++) begin
      drive_instr(32'h200 + 32'(4 * i), 32'h0000_0033, 5'd1, 32'(i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      drive_bubble(1'b0);
      tick();
    end
    check("cnt_pc", 64'(retire_pc_o), 64'h224);
`ifdef WB_INSTRET_EN
    check("instret", instret_o, 64'd10);
`else
    check("instret", instret_o, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
